// File: rtl/dcfifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing the single write port of a dual-clock FIFO.
// Lives entirely in the FIFO write clock domain. Once a requester wins, its grant is held
// until the last beat of its packet is accepted, so packets are never interleaved.
// New grants are throttled by the FIFO's wrusedw/wrfull; an ongoing packet only obeys wrfull.
module dcfifo_wr_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_W       = 512,
    parameter int unsigned USEDW_W      = 4,
    parameter int unsigned AFULL_THRESH = 6,
    parameter int unsigned MAX_BEATS    = 16,
    // Derived widths; not meant to be overridden
    parameter int unsigned IdW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        wrclk,
    input  logic                        aclr_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           fifo_data,
    output logic                        fifo_wrreq,
    input  logic                        fifo_wrfull,
    input  logic [USEDW_W-1:0]          fifo_wrusedw,
    output logic [IdW-1:0]              grant_id,
    output logic                        grant_active,
    output logic [15:0]                 pkt_count,
    output logic                        err_overrun
);

    localparam int unsigned BcW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [IdW:0] NumReqL = (IdW + 1)'(NUM_REQ);
    localparam logic [IdW-1:0] LastIdL = IdW'(NUM_REQ - 1);
    localparam logic [BcW-1:0] LastBeatL = BcW'(MAX_BEATS - 1);

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } state_e;

    state_e             state_q, state_d;
    logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]     grant_id_q, grant_id_d;
    logic [BcW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [15:0]        pkt_count_q, pkt_count_d;
    logic               err_q, err_d;

    logic [2*NUM_REQ-1:0] rot_dbl;
    logic [NUM_REQ-1:0]   rot_valid;
    logic                 arb_found;
    logic [IdW-1:0]       arb_off;
    logic [IdW:0]         arb_sum;
    logic [IdW-1:0]       arb_winner;

    logic               locked;
    logic               can_grant;
    logic               gnt_valid;
    logic               gnt_last;
    logic               accept;
    logic               beat_at_max;
    logic               release_pkt;
    logic               overrun_hit;
    logic [IdW-1:0]     next_ptr;

    assign locked    = (state_q == StLocked);
    assign gnt_valid = req_valid[grant_id_q];
    assign gnt_last  = req_last[grant_id_q];
    assign accept    = locked & gnt_valid & ~fifo_wrfull;

    // Almost-full only gates new grants; a locked packet keeps going until wrfull
    assign can_grant = (|req_valid) & ~fifo_wrfull & (32'(fifo_wrusedw) < AFULL_THRESH);

    assign beat_at_max = (beat_cnt_q == LastBeatL);
    assign release_pkt = accept & (gnt_last | beat_at_max);
    assign overrun_hit = accept & ~gnt_last & beat_at_max;

    // Round-robin pointer moves just past the requester whose packet completed
    assign next_ptr = (grant_id_q == LastIdL) ? '0 : grant_id_q + 1'b1;

    // Winner search: rotate valids so rr_ptr sits at bit 0, take lowest set bit, rotate back
    always_comb begin
        rot_dbl   = {req_valid, req_valid} >> rr_ptr_q;
        rot_valid = rot_dbl[NUM_REQ-1:0];
        arb_found = 1'b0;
        arb_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                arb_found = 1'b1;
                arb_off   = IdW'(k);
            end
        end
        arb_sum = {1'b0, rr_ptr_q} + {1'b0, arb_off};
        if (arb_sum >= NumReqL) begin
            arb_sum = arb_sum - NumReqL;
        end
        arb_winner = arb_sum[IdW-1:0];
    end

    // Next-state logic for the grant FSM and its bookkeeping registers
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        beat_cnt_d  = beat_cnt_q;
        pkt_count_d = pkt_count_q;
        err_d       = err_q;
        unique case (state_q)
            StIdle: begin
                if (can_grant && arb_found) begin
                    state_d    = StLocked;
                    grant_id_d = arb_winner;
                    beat_cnt_d = '0;
                end
            end
            StLocked: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // An overrun releases exactly like a last beat, then sets the sticky flag
                if (release_pkt) begin
                    state_d     = StIdle;
                    rr_ptr_d    = next_ptr;
                    pkt_count_d = pkt_count_q + 16'd1;
                end
                if (overrun_hit) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset abandons any packet in flight without extra writes
    always_ff @(posedge wrclk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            beat_cnt_q  <= '0;
            pkt_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            beat_cnt_q  <= beat_cnt_d;
            pkt_count_q <= pkt_count_d;
            err_q       <= err_d;
        end
    end

    // Handshake to the grantee only; all other requesters see ready low
    always_comb begin
        req_ready = '0;
        if (locked && !fifo_wrfull) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    // Data mux from the grantee's slice; driven to zero while no packet is locked
    always_comb begin
        fifo_data = '0;
        if (locked) begin
            fifo_data = req_data[int'(grant_id_q) * DATA_W +: DATA_W];
        end
    end

    assign fifo_wrreq   = accept;
    assign grant_id     = grant_id_q;
    assign grant_active = locked;
    assign pkt_count    = pkt_count_q;
    assign err_overrun  = err_q;

endmodule

// File: doc/dcfifo_wr_arbiter.md
Name: dcfifo_wr_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares the single write port of a dcfifo_mixed_widths instance among NUM_REQ requesters. It sits in the write clock domain, between router input ports and the FIFO write side.
- Once a requester is granted, the grant is held until that requester's last beat is accepted, so packets are never interleaved in the FIFO.
- New grants are throttled using the FIFO's wrusedw and wrfull outputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 512, beat width; equals the FIFO lpm_width.
- USEDW_W, 4, width of fifo_wrusedw; equals the FIFO lpm_widthu.
- AFULL_THRESH, 6, no new grant is issued while fifo_wrusedw >= AFULL_THRESH.
- MAX_BEATS, 16, maximum beats per packet before the overrun error is raised.

Ports:
- wrclk  in  1  write-domain clock; all logic is on its rising edge.
- aclr_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  marks the final beat of a packet.
- req_ready  out  NUM_REQ  beat accepted when valid&ready.
- fifo_data  out  DATA_W  goes to FIFO data.
- fifo_wrreq  out  1  goes to FIFO wrreq.
- fifo_wrfull  in  1  from FIFO wrfull.
- fifo_wrusedw  in  USEDW_W  from FIFO wrusedw.
- grant_id  out  $clog2(NUM_REQ)  current or most recent grantee.
- grant_active  out  1  a packet is locked.
- pkt_count  out  16  packets completed, wrapping counter.
- err_overrun  out  1  sticky; set when a packet exceeds MAX_BEATS.

Behaviour:
- Reset (aclr_n=0, asynchronous): state=IDLE, rr_ptr=0, grant_id=0, grant_active=0, beat_cnt=0, pkt_count=0, err_overrun=0. Combinational outputs then give req_ready=0, fifo_wrreq=0, fifo_data=0.
- Reset asserted mid-packet: the packet is abandoned with no further writes. The arbiter performs no FIFO flush, because the FIFO shares aclr.
- FSM IDLE:
  - Arbitration is allowed when any req_valid=1, fifo_wrfull=0 and fifo_wrusedw < AFULL_THRESH.
  - The winner is the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - Next edge: state=LOCKED, grant_id=winner, grant_active=1, beat_cnt=0.
  - No beat transfers while in IDLE.
- FSM LOCKED:
  - req_ready[grant_id] = !fifo_wrfull. All other req_ready are 0.
  - fifo_wrreq = req_valid[grant_id] & !fifo_wrfull.
  - fifo_data = the grantee's req_data slice, as a combinational mux.
  - Each accepted beat increments beat_cnt.
  - Accepted beat with req_last=1: next edge gives state=IDLE, grant_active=0, rr_ptr=(grant_id+1) mod NUM_REQ, pkt_count+1 (wraps 0xFFFF->0). grant_id holds its value.
  - Accepted beat without last when beat_cnt==MAX_BEATS-1: err_overrun is set to 1 (sticky until reset) and the grant is released as if last had been seen, including the rr_ptr advance and pkt_count increment.
- Stalls: in LOCKED, req_valid[grant_id]=0 or fifo_wrfull=1 stalls the transfer. The grant is held indefinitely and there is no timeout.
- The almost-full threshold is checked only at grant time. An in-progress packet continues until wrfull.
- Minimum latency: valid at cycle t in IDLE gives first accept at t+1. Back-to-back packets have a one-cycle IDLE bubble between them.
- Requesters other than the grantee may change valid/data freely; their inputs are ignored.
- NUM_REQ=1: the arbiter degenerates to a single lock, and rr_ptr stays 0.

Test Plan:
- Single packet: req0 sends 3 beats D0..D2, last on D2, FIFO empty. Expect grant at cycle 1, fifo_wrreq high for cycles 1-3 with data D0,D1,D2, then grant_active=0 at cycle 4 and pkt_count=1.
- Fairness: all 4 requesters continuously present 2-beat packets. Expect grant order 0,1,2,3,0. Every 3-cycle window (one IDLE cycle plus two beats) carries exactly one packet, and no interleaving occurs.
- Throttle: fifo_wrusedw=6 with req1 valid. Expect no grant. Drop wrusedw to 5; expect grant_id=1 the next cycle.
- Full stall: fifo_wrfull=1 after beat 1 of a 4-beat packet from req2. Expect req_ready=0 and fifo_wrreq=0 while full, with the grant held. Release full; expect beats 2-4 written in order with no loss or duplication.
- Overrun: req3 sends 17 beats with no last, MAX_BEATS=16. Expect err_overrun=1 after the 16th accept, grant released, and rr_ptr=0.
- Async reset mid-packet: drop aclr_n during beat 2 of req1's packet. Expect all outputs at reset values immediately, without waiting for a clock edge. After release, a req0 packet is granted first.
